// File: rtl/alu_iter.sv
// Width-generic ALU: one-cycle arithmetic/logic ops plus W-cycle shift-add multiply and
// restoring divide, fed one request at a time through a valid/ready handshake.
module alu_iter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned INST_WIDTH = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_data_a,
  input  logic [DATA_WIDTH-1:0] i_data_b,
  input  logic [INST_WIDTH-1:0] i_inst,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_overflow,
  output logic                  o_valid
);
  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned SW = $clog2(DATA_WIDTH);

  localparam logic [INST_WIDTH-1:0] OpAdd  = INST_WIDTH'(0);
  localparam logic [INST_WIDTH-1:0] OpSub  = INST_WIDTH'(1);
  localparam logic [INST_WIDTH-1:0] OpSmul = INST_WIDTH'(2);
  localparam logic [INST_WIDTH-1:0] OpUmul = INST_WIDTH'(3);
  localparam logic [INST_WIDTH-1:0] OpSdiv = INST_WIDTH'(4);
  localparam logic [INST_WIDTH-1:0] OpUdiv = INST_WIDTH'(5);
  localparam logic [INST_WIDTH-1:0] OpUrem = INST_WIDTH'(6);
  localparam logic [INST_WIDTH-1:0] OpMax  = INST_WIDTH'(7);
  localparam logic [INST_WIDTH-1:0] OpMin  = INST_WIDTH'(8);
  localparam logic [INST_WIDTH-1:0] OpAnd  = INST_WIDTH'(9);
  localparam logic [INST_WIDTH-1:0] OpOr   = INST_WIDTH'(10);
  localparam logic [INST_WIDTH-1:0] OpXor  = INST_WIDTH'(11);
  localparam logic [INST_WIDTH-1:0] OpShl  = INST_WIDTH'(12);
  localparam logic [INST_WIDTH-1:0] OpSra  = INST_WIDTH'(13);
  localparam logic [INST_WIDTH-1:0] OpRev  = INST_WIDTH'(14);

  typedef enum logic {StIdle, StCalc} state_e;
  typedef enum logic [2:0] {KSmul, KUmul, KSdiv, KUdiv, KUrem} kind_e;

  state_e          r_state, w_state_n;
  kind_e           r_kind, w_kind_n;
  logic [SW-1:0]   r_cnt, w_cnt_n;
  logic [W-1:0]    r_hi, w_hi_n, r_lo, w_lo_n, r_m, w_m_n;
  logic            r_neg, w_neg_n, r_bzero, w_bzero_n;
  logic [W-1:0]    r_data, w_data_n;
  logic            r_ovf, w_ovf_n, r_valid, w_valid_n;

  logic            w_accept, w_a_neg, w_b_neg;
  logic [W-1:0]    w_a_mag, w_b_mag, w_sum, w_dif;
  logic [W-1:0]    w_alu_res;
  logic            w_alu_ovf, w_alu_iter;
  logic [W:0]      w_msum, w_rsh;
  logic [W-1:0]    w_rsub;
  logic            w_rge;
  logic [W-1:0]    w_step_hi, w_step_lo;
  logic [2*W-1:0]  w_prod, w_prod_s;
  logic [W-1:0]    w_quo_s, w_fix_data;
  logic            w_fix_ovf;

  assign o_ready    = (r_state == StIdle);
  assign o_data     = r_data;
  assign o_overflow = r_ovf;
  assign o_valid    = r_valid;

  assign w_accept = i_valid & o_ready;
  assign w_a_neg  = i_data_a[W-1];
  assign w_b_neg  = i_data_b[W-1];
  assign w_a_mag  = w_a_neg ? -i_data_a : i_data_a;
  assign w_b_mag  = w_b_neg ? -i_data_b : i_data_b;
  assign w_sum    = i_data_a + i_data_b;
  assign w_dif    = i_data_a - i_data_b;

  always_comb begin
    w_alu_res  = '0;
    w_alu_ovf  = 1'b0;
    w_alu_iter = 1'b0;
    case (i_inst)
      OpAdd: begin
        w_alu_res = w_sum;
        w_alu_ovf = (w_a_neg == w_b_neg) && (w_sum[W-1] != w_a_neg);
      end
      OpSub: begin
        w_alu_res = w_dif;
        w_alu_ovf = (w_a_neg != w_b_neg) && (w_dif[W-1] != w_a_neg);
      end
      OpSmul, OpUmul, OpSdiv, OpUdiv, OpUrem: w_alu_iter = 1'b1;
      OpMax: w_alu_res = ($signed(i_data_a) > $signed(i_data_b)) ? i_data_a : i_data_b;
      OpMin: w_alu_res = ($signed(i_data_a) < $signed(i_data_b)) ? i_data_a : i_data_b;
      OpAnd: w_alu_res = i_data_a & i_data_b;
      OpOr:  w_alu_res = i_data_a | i_data_b;
      OpXor: w_alu_res = i_data_a ^ i_data_b;
      OpShl: w_alu_res = i_data_a << i_data_b[SW-1:0];
      OpSra: w_alu_res = $unsigned($signed(i_data_a) >>> i_data_b[SW-1:0]);
      OpRev: for (int i = 0; i < W; i++) w_alu_res[i] = i_data_a[W-1-i];
      default: ;
    endcase
  end

  // Multiply: {hi,lo} shifts right, lo holds the multiplier. Divide: {hi,lo} shifts left,
  // hi is the partial remainder and quotient bits enter lo from the bottom.
  always_comb begin
    w_msum = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_m} : '0);
    w_rsh  = {r_hi, r_lo[W-1]};
    w_rge  = w_rsh >= {1'b0, r_m};
    w_rsub = w_rsh[W-1:0] - r_m;
    if (r_kind == KSmul || r_kind == KUmul) begin
      w_step_hi = w_msum[W:1];
      w_step_lo = {w_msum[0], r_lo[W-1:1]};
    end else begin
      w_step_hi = w_rge ? w_rsub : w_rsh[W-1:0];
      w_step_lo = {r_lo[W-2:0], w_rge};
    end
  end

  always_comb begin
    w_prod     = {w_step_hi, w_step_lo};
    w_prod_s   = r_neg ? -w_prod : w_prod;
    w_quo_s    = r_neg ? -w_step_lo : w_step_lo;
    w_fix_data = w_step_lo;
    w_fix_ovf  = 1'b0;
    case (r_kind)
      KSmul: begin
        w_fix_data = w_prod_s[W-1:0];
        w_fix_ovf  = ~((&w_prod_s[2*W-1:W-1]) | ~(|w_prod_s[2*W-1:W-1]));
      end
      KUmul: w_fix_ovf = |w_step_hi;
      KSdiv: begin
        if (r_bzero) begin
          w_fix_data = '1;
          w_fix_ovf  = 1'b1;
        end else begin
          // Only MIN / -1 yields a positive quotient with the top bit set.
          w_fix_data = w_quo_s;
          w_fix_ovf  = ~r_neg & w_step_lo[W-1];
        end
      end
      KUdiv: w_fix_ovf = r_bzero;
      KUrem: begin
        w_fix_data = w_step_hi;
        w_fix_ovf  = r_bzero;
      end
      default: ;
    endcase
  end

  always_comb begin
    w_state_n = r_state;
    w_kind_n  = r_kind;
    w_cnt_n   = r_cnt;
    w_hi_n    = r_hi;
    w_lo_n    = r_lo;
    w_m_n     = r_m;
    w_neg_n   = r_neg;
    w_bzero_n = r_bzero;
    w_data_n  = r_data;
    w_ovf_n   = r_ovf;
    w_valid_n = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_accept && !w_alu_iter) begin
          w_data_n  = w_alu_res;
          w_ovf_n   = w_alu_ovf;
          w_valid_n = 1'b1;
        end else if (w_accept) begin
          w_state_n = StCalc;
          w_cnt_n   = SW'(W - 1);
          w_hi_n    = '0;
          w_neg_n   = 1'b0;
          w_bzero_n = ~|i_data_b;
          case (i_inst)
            OpSmul: begin
              w_kind_n = KSmul;
              w_lo_n   = w_b_mag;
              w_m_n    = w_a_mag;
              w_neg_n  = w_a_neg ^ w_b_neg;
            end
            OpUmul: begin
              w_kind_n = KUmul;
              w_lo_n   = i_data_b;
              w_m_n    = i_data_a;
            end
            OpSdiv: begin
              w_kind_n = KSdiv;
              w_lo_n   = w_a_mag;
              w_m_n    = w_b_mag;
              w_neg_n  = w_a_neg ^ w_b_neg;
            end
            OpUdiv: begin
              w_kind_n = KUdiv;
              w_lo_n   = i_data_a;
              w_m_n    = i_data_b;
            end
            default: begin
              w_kind_n = KUrem;
              w_lo_n   = i_data_a;
              w_m_n    = i_data_b;
            end
          endcase
        end
      end
      StCalc: begin
        w_hi_n  = w_step_hi;
        w_lo_n  = w_step_lo;
        w_cnt_n = r_cnt - SW'(1);
        if (r_cnt == '0) begin
          w_state_n = StIdle;
          w_data_n  = w_fix_data;
          w_ovf_n   = w_fix_ovf;
          w_valid_n = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= StIdle;
      r_kind  <= KSmul;
      r_cnt   <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_m     <= '0;
      r_neg   <= 1'b0;
      r_bzero <= 1'b0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_kind  <= w_kind_n;
      r_cnt   <= w_cnt_n;
      r_hi    <= w_hi_n;
      r_lo    <= w_lo_n;
      r_m     <= w_m_n;
      r_neg   <= w_neg_n;
      r_bzero <= w_bzero_n;
      r_data  <= w_data_n;
      r_ovf   <= w_ovf_n;
      r_valid <= w_valid_n;
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Bench for alu_iter (W=32): vector table through a result scoreboard, plus hand-timed
// sequences for iterative latency, held requests and reset abort.
module tb_alu_iter;
  localparam int unsigned W = 32;
  localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB = 4'd1,  OP_SMUL = 4'd2, OP_UMUL = 4'd3;
  localparam logic [3:0] OP_SDIV = 4'd4, OP_UDIV = 4'd5, OP_UREM = 4'd6, OP_MAX = 4'd7;
  localparam logic [3:0] OP_MIN = 4'd8,  OP_AND = 4'd9,  OP_OR = 4'd10,  OP_XOR = 4'd11;
  localparam logic [3:0] OP_SHL = 4'd12, OP_SRA = 4'd13, OP_REV = 4'd14, OP_RSV = 4'd15;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [W-1:0]  i_data_a, i_data_b;
  logic [3:0]    i_inst;
  logic          i_valid;
  logic          o_ready, o_overflow, o_valid;
  logic [W-1:0]  o_data;

  alu_iter #(.DATA_WIDTH(W), .INST_WIDTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_data_a(i_data_a), .i_data_b(i_data_b),
    .i_inst(i_inst), .i_valid(i_valid), .o_ready(o_ready), .o_data(o_data),
    .o_overflow(o_overflow), .o_valid(o_valid)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   op;
    logic [W-1:0] d;
    logic         ovf;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic         ovf;
    string        tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst && o_valid) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got o_valid=1 data=%0h want no pending result", o_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check({e.tag, "_data"}, o_data, e.d);
        check({e.tag, "_ovf"}, o_overflow, e.ovf);
      end
    end
  end

  // Drive a request and hold it until accepted; returns at the negedge after the accept edge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op,
                      input logic [W-1:0] d, input logic ovf, input string tag,
                      output int waited);
    exp_t e;
    i_data_a = a;
    i_data_b = b;
    i_inst   = op;
    i_valid  = 1'b1;
    waited   = 0;
    while (!o_ready && waited < 100) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout %s: got o_ready=0 want 1 within 100 cycles", tag);
    end else begin
      e.d = d;
      e.ovf = ovf;
      e.tag = tag;
      q.push_back(e);
    end
    @(negedge i_clk);
  endtask

  // Called in cycle k+1 of an iterative op: ready/valid low for W cycles, then both high.
  task automatic busy_window(input string tag);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < W; i++) begin
      if (o_ready || o_valid) ok = 1'b0;
      @(negedge i_clk);
    end
    check({tag, "_busy"}, ok, 1'b1);
    check({tag, "_done_valid_ready"}, {o_valid, o_ready}, 2'b11);
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge i_clk);
    check({tag, "_drain"}, q.size(), 0);
  endtask

  vec_t tbl [27];
  int   w;
  int   seen;
  logic ok;

  initial begin
    tbl[0]  = '{32'h7FFFFFFF, 32'h00000001, OP_ADD,  32'h80000000, 1'b1};
    tbl[1]  = '{32'h00000005, 32'h00000003, OP_ADD,  32'h00000008, 1'b0};
    tbl[2]  = '{32'h80000000, 32'h00000001, OP_SUB,  32'h7FFFFFFF, 1'b1};
    tbl[3]  = '{32'h00000003, 32'h00000005, OP_SUB,  32'hFFFFFFFE, 1'b0};
    tbl[4]  = '{32'hFFFFFFFF, 32'h00000002, OP_MAX,  32'h00000002, 1'b0};
    tbl[5]  = '{32'hFFFFFFFF, 32'h00000002, OP_MIN,  32'hFFFFFFFF, 1'b0};
    tbl[6]  = '{32'hF0F0F0F0, 32'h0FF00FF0, OP_AND,  32'h00F000F0, 1'b0};
    tbl[7]  = '{32'h12340000, 32'h00005678, OP_OR,   32'h12345678, 1'b0};
    tbl[8]  = '{32'hFFFF0000, 32'h0F0F0F0F, OP_XOR,  32'hF0F00F0F, 1'b0};
    tbl[9]  = '{32'h00000001, 32'h00000023, OP_SHL,  32'h00000008, 1'b0};
    tbl[10] = '{32'h80000000, 32'h00000004, OP_SRA,  32'hF8000000, 1'b0};
    tbl[11] = '{32'h12345678, 32'h00000000, OP_REV,  32'h1E6A2C48, 1'b0};
    tbl[12] = '{32'hFFFFFFFF, 32'hFFFFFFFF, OP_RSV,  32'h00000000, 1'b0};
    tbl[13] = '{32'hFFFFFFFD, 32'h00000007, OP_SMUL, 32'hFFFFFFEB, 1'b0};
    tbl[14] = '{32'h00010000, 32'h00010000, OP_UMUL, 32'h00000000, 1'b1};
    tbl[15] = '{32'h7FFFFFFF, 32'h00000002, OP_SMUL, 32'hFFFFFFFE, 1'b1};
    tbl[16] = '{32'h80000000, 32'hFFFFFFFF, OP_SMUL, 32'h80000000, 1'b1};
    tbl[17] = '{32'hFFFFFFFF, 32'hFFFFFFFF, OP_UMUL, 32'h00000001, 1'b1};
    tbl[18] = '{32'hFFFFFFF9, 32'h00000002, OP_SDIV, 32'hFFFFFFFD, 1'b0};
    tbl[19] = '{32'h00000007, 32'h00000003, OP_UREM, 32'h00000001, 1'b0};
    tbl[20] = '{32'h00000005, 32'h00000000, OP_UDIV, 32'hFFFFFFFF, 1'b1};
    tbl[21] = '{32'h80000000, 32'hFFFFFFFF, OP_SDIV, 32'h80000000, 1'b1};
    tbl[22] = '{32'h00000007, 32'h00000000, OP_SDIV, 32'hFFFFFFFF, 1'b1};
    tbl[23] = '{32'h00000009, 32'h00000000, OP_UREM, 32'h00000009, 1'b1};
    tbl[24] = '{32'h00000064, 32'h00000007, OP_UDIV, 32'h0000000E, 1'b0};
    tbl[25] = '{32'h00000064, 32'hFFFFFFF9, OP_SDIV, 32'hFFFFFFF2, 1'b0};
    tbl[26] = '{32'h00000000, 32'h80000000, OP_SMUL, 32'h00000000, 1'b0};

    i_rst = 1'b1;
    i_valid = 1'b0;
    i_data_a = '0;
    i_data_b = '0;
    i_inst = '0;
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    check("reset_state", {o_ready, o_valid, o_overflow, o_data}, {1'b1, 1'b0, 1'b0, 32'h0});

    // One-cycle add: result visible in the cycle after accept, then held with valid low.
    send(32'h7FFFFFFF, 32'h00000001, OP_ADD, 32'h80000000, 1'b1, "add_ovf", w);
    i_valid = 1'b0;
    check("add_latency", {o_valid, o_overflow, o_data}, {1'b1, 1'b1, 32'h80000000});
    @(negedge i_clk);
    check("add_hold", {o_valid, o_overflow, o_data}, {1'b0, 1'b1, 32'h80000000});

    // Four back-to-back xors.
    ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] a;
      a = 32'h11111111 * (i + 1);
      send(a, 32'h0F0F0F0F, OP_XOR, a ^ 32'h0F0F0F0F, 1'b0, $sformatf("xor%0d", i), w);
      if (!(o_valid && o_ready) || w != 0) ok = 1'b0;
    end
    i_valid = 1'b0;
    check("xor_back_to_back", ok, 1'b1);
    drain("xor");

    for (int i = 0; i < 27; i++)
      send(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].d, tbl[i].ovf, $sformatf("vec%0d", i), w);
    i_valid = 1'b0;
    drain("table");

    // Iterative latency and ready timing.
    send(32'hFFFFFFFD, 32'h00000007, OP_SMUL, 32'hFFFFFFEB, 1'b0, "smul_timed", w);
    i_valid = 1'b0;
    busy_window("smul_timed");

    // Second request held during CALC: accepted only in the o_valid cycle.
    send(32'h00010000, 32'h00010000, OP_UMUL, 32'h00000000, 1'b1, "umul_first", w);
    send(32'hFFFFFFF9, 32'h00000002, OP_SDIV, 32'hFFFFFFFD, 1'b0, "sdiv_held", w);
    i_valid = 1'b0;
    check("held_accept_wait", w, W);
    busy_window("sdiv_held");
    drain("held");

    // Reset 10 cycles into a multiply: outputs clear at once and no result ever appears.
    send(32'h00001234, 32'h00000010, OP_UMUL, 32'h00012340, 1'b0, "umul_aborted", w);
    i_valid = 1'b0;
    repeat (9) @(negedge i_clk);
    i_rst = 1'b1;
    q.delete();
    #1;
    check("reset_abort_outputs", {o_ready, o_valid, o_overflow, o_data},
          {1'b1, 1'b0, 1'b0, 32'h0});
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    seen = 0;
    repeat (W + 5) begin
      @(negedge i_clk);
      if (o_valid) seen++;
    end
    check("no_valid_after_abort", seen, 0);
    send(32'h00000002, 32'h00000002, OP_ADD, 32'h00000004, 1'b0, "add_after_reset", w);
    i_valid = 1'b0;
    drain("post_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
